// File: rtl/uart_tx_unit.sv
// Byte-stream UART transmitter: small byte FIFO feeding an 8N1 serialiser, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_unit #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    d_rx,
  input  logic                          vld_rx,
  output logic                          rdy_rx,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int BC_W    = $clog2(BIT_CYC);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BC_W-1:0]   baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        sh_q, sh_d;
  logic              txd_q, txd_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic [7:0]        mem_q [FIFO_DEPTH];

  logic              wr_en;
  logic              pop;
  logic              bit_end;

  assign rdy_rx   = (cnt_q != CNT_FULL);
  assign wr_en    = vld_rx && rdy_rx;
  assign bit_end  = (baud_q == BC_LAST);
  assign txd      = txd_q;
  assign busy     = (state_q != IDLE) || (cnt_q != '0);
  assign fifo_cnt = cnt_q;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          sh_d    = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
          par_d   = ^mem_q[rd_ptr_q];
`endif
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          sh_d  = {1'b0, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is a registered function of the current state, so it trails the FSM by one clock.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      START:  txd_d = 1'b0;
      DATA:   txd_d = sh_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY: txd_d = par_q;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // NOTE: storage array has no reset; occupancy and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= d_rx;
  end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Self-checking bench for uart_tx_unit: frame-timing vector table, hand-written FIFO/reset
// sequences and random traffic scored by a line-level UART decoder.
module tb_uart_tx_unit;

  localparam int CLK_FREQ   = 16;
  localparam int BAUD       = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_CYC    = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BIT_CYC;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d_rx = 8'h00;
  logic       vld_rx = 1'b0;
  logic       rdy_rx;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int frames_seen = 0;
  int exp_total = 0;
  logic [7:0] exp_q[$];

  uart_tx_unit #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .d_rx    (d_rx),
    .vld_rx  (vld_rx),
    .rdy_rx  (rdy_rx),
    .txd     (txd),
    .busy    (busy),
    .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;   // expected even-parity bit of data
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer one byte and hold it until accepted; returns the number of refused edges.
  task automatic send(input logic [7:0] b, input int budget, output int waited);
    logic r;
    waited = 0;
    d_rx   = b;
    vld_rx = 1'b1;
    forever begin
      r = rdy_rx;
      @(posedge clk); #1;
      if (r) break;
      waited++;
      if (waited >= budget) break;
    end
    vld_rx = 1'b0;
    check("send_accept", r, 1);
    if (r) begin
      exp_q.push_back(b);
      exp_total++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (busy !== 1'b0 && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    check("idle_reached", busy, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  // Line-level reference: decode whatever appears on txd as UART frames.
  initial begin : monitor
    logic [10:0] bits;
    logic        prev;
    logic        bad;
    logic        aborted;
    logic [7:0]  got;
    forever begin
      @(posedge clk); #2;
      if (rst === 1'b1 && txd === 1'b0) begin
        bits = '0; bad = 1'b0; aborted = 1'b0; prev = 1'b0;
        for (int b = 0; b < NBITS && !aborted; b++) begin
          for (int s = 0; s < BIT_CYC; s++) begin
            if (b != 0 || s != 0) begin @(posedge clk); #2; end
            if (rst !== 1'b1) begin aborted = 1'b1; break; end
            if (s == 0) prev = txd;
            else if (txd !== prev) bad = 1'b1;
            if (s == BIT_CYC / 2) bits[b] = txd;
          end
        end
        if (!aborted) begin
          got = bits[8:1];
          frames_seen++;
          check("frame_bit_width", bad, 0);
          check("start_bit", bits[0], 0);
          check("stop_bit", bits[NBITS-1], 1);
`ifdef UART_TX_PARITY_EN
          check("parity_bit", bits[9], ^got);
`endif
          if (exp_q.size() == 0) check("unexpected_frame", got, 9'h100);
          else check("line_byte", got, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t        vecs[6];
    logic [10:0] exp_bits;
    logic [BIT_CYC-1:0] seg;
    int          w;
    int          hi;

    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h03, 1'b0};
    vecs[3] = '{8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b0};
    vecs[5] = '{8'h80, 1'b1};

    // Reset held with a byte on offer: nothing may be taken.
    rst = 1'b0; vld_rx = 1'b1; d_rx = 8'hEE;
    repeat (4) begin @(posedge clk); #1; end
    check("reset_txd", txd, 1);
    check("reset_rdy", rdy_rx, 1);
    check("reset_busy", busy, 0);
    check("reset_cnt", fifo_cnt, 0);
    vld_rx = 1'b0;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("post_reset_cnt", fifo_cnt, 0);
    check("post_reset_txd", txd, 1);

    // Exact frame timing for single bytes written in IDLE.
    for (int i = 0; i < 6; i++) begin
      wait_idle(2 * FRAME);
`ifdef UART_TX_PARITY_EN
      exp_bits = {1'b1, vecs[i].par, vecs[i].data, 1'b0};
`else
      exp_bits = {1'b0, 1'b1, vecs[i].data, 1'b0};
`endif
      d_rx = vecs[i].data; vld_rx = 1'b1;
      check("rdy_idle", rdy_rx, 1);
      @(posedge clk); #1;
      vld_rx = 1'b0;
      exp_q.push_back(vecs[i].data);
      exp_total++;
      check("cnt_after_write", fifo_cnt, 1);
      for (int k = 1; k <= FRAME + 2; k++) begin
        @(posedge clk); #1;
        if (k == 1) begin
          check("txd_before_start", txd, 1);
          check("cnt_after_pop", fifo_cnt, 0);
        end else if (k < 2 + FRAME) begin
          seg[(k-2) % BIT_CYC] = txd;
          if ((k-2) % BIT_CYC == BIT_CYC - 1)
            check($sformatf("vec%0d_bit%0d", i, (k-2) / BIT_CYC), seg,
                  {BIT_CYC{exp_bits[(k-2) / BIT_CYC]}});
        end else begin
          check("txd_after_frame", txd, 1);
        end
        if (k == FRAME)     check("busy_last_cycle", busy, 1);
        if (k == FRAME + 1) check("busy_fall", busy, 0);
      end
    end
    wait_idle(2 * FRAME);

    // Fill: five bytes go in without stall, the sixth waits for the second pop.
    for (int b = 1; b <= 5; b++) begin
      send(8'(b), 4, w);
      check($sformatf("no_stall_%0d", b), w, 0);
    end
    check("full_cnt", fifo_cnt, FIFO_DEPTH);
    check("full_rdy", rdy_rx, 0);
    send(8'h06, 2 * FRAME + 10, w);
    check("hold_cycles", w, FRAME - 2);
    wait_idle(8 * FRAME);

    // Wrap-around: ten bytes with vld_rx held high.
    for (int b = 0; b < 10; b++) send(8'h30 + 8'(b), 2 * FRAME + 10, w);
    wait_idle(8 * FRAME);

    // Random traffic with random gaps.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      send(8'($urandom), 2 * FRAME + 10, w);
    end
    wait_idle(8 * FRAME);

    // Reset during data bit 3 of 0x55 with another byte queued.
    send(8'h55, 4, w);
    send(8'h66, 4, w);
    repeat (70) begin @(posedge clk); #1; end
    check("pre_reset_txd", txd, 0);
    check("pre_reset_cnt", fifo_cnt, 1);
    #2 rst = 1'b0;
    #1;
    check("async_reset_txd", txd, 1);
    check("async_reset_cnt", fifo_cnt, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_rdy", rdy_rx, 1);
    exp_total -= exp_q.size();
    exp_q.delete();
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (txd === 1'b1) hi++;
    end
    check("quiet_after_reset", hi, 20);
    check("empty_after_reset", fifo_cnt, 0);
    send(8'h0F, 4, w);
    wait_idle(2 * FRAME);

    check("frames_decoded", frames_seen, exp_total);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_unit.md
Name: uart_tx_unit

Overview:
- Byte-to-serial UART transmitter for the serial debug unit.
- Consumes the debug processor's outgoing byte stream (d_rx / vld_rx / rdy_rx) and buffers it in a small FIFO.
- Serialises each byte onto the host TX line as 8N1, LSB first.
- Sits between the debug command processor and the board's UART pin.

Parameters:
- CLK_FREQ, 100000000, clk frequency in Hz.
- BAUD, 115200, line rate in bit/s; bit period BIT_CYC = CLK_FREQ/BAUD (integer division, must be >= 2).
- FIFO_DEPTH, 16, byte FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- d_rx  input  8  byte to transmit.
- vld_rx  input  1  d_rx valid.
- rdy_rx  output  1  unit can accept a byte (FIFO not full).
- txd  output  1  serial line; idle high.
- busy  output  1  FIFO non-empty or a frame in progress.
- fifo_cnt  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - txd=1, rdy_rx=1, busy=0, fifo_cnt=0.
  - FSM to IDLE; FIFO pointers, bit counter and baud counter cleared.
  - Reset asserted mid-frame truncates the frame immediately; txd goes high in the same reset assertion, not at the next edge.
- Input handshake: a byte is written on a rising clk edge where vld_rx=1 and rdy_rx=1.
  - rdy_rx = (fifo_cnt != FIFO_DEPTH), combinational from registered count.
  - If vld_rx=1 while full, the byte is not taken; the source holds it.
- FIFO:
  - Circular buffer with wrap-around read/write pointers.
  - Simultaneous write and pop in one cycle: count unchanged, both pointers advance.
  - A simultaneous write and pop is legal when full: the pop frees the slot in the same cycle, but rdy_rx is still 0 that cycle, so no write occurs.
  - Pop occurs in IDLE when the FIFO is non-empty. The popped byte is latched into shift register sh[7:0].
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1; if fifo_cnt != 0, pop, load sh, clear baud_cnt, go to START at the next edge.
  - START: txd=0 for BIT_CYC cycles.
  - DATA: txd=sh[0]; every BIT_CYC cycles shift sh right and increment bit_idx (0..7). After bit 7 completes, go to STOP.
  - STOP: txd=1 for BIT_CYC cycles, then IDLE.
  - A back-to-back frame starts one clk after STOP ends (one IDLE cycle of high, within tolerance).
- Baud counter: counts 0..BIT_CYC-1. State or bit advance occurs when baud_cnt == BIT_CYC-1, then it wraps to 0.
- txd is registered (no glitches); frame length = 10*BIT_CYC clocks.
- busy = (state != IDLE) || (fifo_cnt != 0).
- Latency: byte written to an empty FIFO in IDLE → start bit appears on txd 2 clk edges after the write edge.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - txd = even parity (XOR of the 8 data bits) for BIT_CYC cycles.
  - Frame becomes 11*BIT_CYC clocks (8E1).
- Undefined: no PARITY state, 8N1 only; parity logic and its register are not synthesised.

Test Plan:
- Use CLK_FREQ=16, BAUD=1 (BIT_CYC=16), FIFO_DEPTH=4.
- Reset: hold rst=0 with vld_rx=1 → txd=1, rdy_rx=1, busy=0, fifo_cnt=0; no byte accepted.
- Single byte 0xA5 written in IDLE:
  - txd low 2 edges later for 16 clk.
  - Then bits 1,0,1,0,0,1,0,1 for 16 clk each.
  - Then high 16 clk.
  - busy falls after the stop bit; total 160 clk.
- Fill: write 0x01,0x02,0x03,0x04,0x05 on consecutive cycles.
  - The first byte pops into the shifter, so 0x01..0x05 are all accepted without stall.
  - A sixth byte 0x06 sees rdy_rx=0 and is held until the 0x02 pop.
  - Line output order 01..06 with no lost or duplicated byte.
- Wrap-around: stream 10 bytes 0x30..0x39 with vld_rx held high. Pointers wrap twice; the decoded line bytes match in order.
- Reset mid-frame: assert rst=0 during DATA bit 3 of 0x55.
  - txd=1 immediately and FIFO empty.
  - After release, writing 0x0F produces one clean frame.
- UART_TX_PARITY_EN defined:
  - 0x07 → parity bit 1; 0x03 → parity bit 0.
  - Each frame is 176 clk.
